riscv_wb_checker: RTL
=====================

# riscv_wb_checker

Synthesizable writeback-stream checker for `riscv_pipeline`.
- Holds a preloaded queue of expected register writes and compares each `wb_e`-qualified writeback, in order, against the queue head.
- Reports match/mismatch counts, the first failing index, a pass verdict and an inactivity timeout.
- Intended for self-checking benches and FPGA bring-up, replacing fixed cycle-delay checks of `wb_a`/`wb_d`/`wb_e`.

## Interface
Parameters:
- `XLEN`, 32, data width of `wb_d`/`exp_d`.
- `RA_W`, 5, register address width.
- `DEPTH`, 16, expected-entry queue depth (power of two, ≥2).
- `TIMEOUT`, 64, RUN-state cycles without `wb_e` before abort (≥1).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `exp_valid`  in  1  expected entry offered.
- `exp_ready`  out  1  entry accepted this cycle when `exp_valid` also high.
- `exp_a`  in  RA_W  expected destination register.
- `exp_d`  in  XLEN  expected write data.
- `start`  in  1  begin checking (IDLE only).
- `clear`  in  1  return from DONE to IDLE.
- `wb_a`  in  RA_W  monitored writeback address.
- `wb_d`  in  XLEN  monitored writeback data.
- `wb_e`  in  1  monitored writeback enable.
- `busy`  out  1  state is RUN.
- `done`  out  1  state is DONE.
- `pass`  out  1  `done` && `err_count`==0 && !`timeout`.
- `timeout`  out  1  RUN aborted by inactivity.
- `mismatch`  out  1  one-cycle pulse, cycle after a failing compare.
- `match_count`  out  $clog2(DEPTH+1)  passing compares.
- `err_count`  out  $clog2(DEPTH+1)  failing compares.
- `first_err_idx`  out  $clog2(DEPTH)  queue index of first failure; valid when `err_count`≠0.

## Operation
States:
- IDLE: `exp_ready` = !full; accepted entries are pushed.
  - `start` with occupancy>0 → RUN.
  - `start` with occupancy 0 is ignored.
- RUN: each cycle with `wb_e`=1 pops the head and compares both `wb_a`==`exp_a` and `wb_d`==`exp_d`.
  - Match → `match_count`+1.
  - Otherwise `err_count`+1, `mismatch` pulses; on the first failure, `first_err_idx` ← pop index (0-based from start).
  - Pop that empties the queue → DONE.
  - `TIMEOUT` consecutive cycles with `wb_e`=0 → DONE with `timeout`=1. Remaining entries stay queued and are not counted.
- DONE: outputs frozen. `clear` → IDLE, flushes the queue and zeroes counters, `timeout` and `first_err_idx`.

Rules:
- `wb_e` outside RUN is ignored.
- `exp_valid` outside IDLE: `exp_ready`=0, nothing pushed.
- `start` in IDLE and `exp_valid` in the same cycle: the entry is pushed and included in the run.
- `clear` outside DONE is ignored. `start` in DONE is ignored.
- Writes to x0 are compared like any other address.
- Counters cannot exceed DEPTH, so no saturation logic is needed.
- Queue pointers are $clog2(DEPTH) bits with wrap; the full/empty distinction uses an explicit occupancy count.

## Timing
- Reset (any state, including mid-RUN): state IDLE, queue empty, `exp_ready`=1, all other outputs 0.
- Compare latency is 1 cycle: counters, `mismatch`, `first_err_idx` and the DONE transition are visible after the edge following the `wb_e` cycle.
- Back-to-back `wb_e` every cycle is sustained.
- The timeout counter resets on every `wb_e` and on RUN entry. Abort is visible at edge `TIMEOUT` after the last activity.

## Configuration
- `RVP_WB_SHADOW_EN` defined:
  - Adds a shadow register file (2^RA_W × XLEN, reset 0), written on every RUN-state `wb_e` with `wb_a`≠0.
  - Adds ports `sh_a` (in, RA_W) and `sh_d` (out, XLEN). `sh_d` is a combinational read; x0 reads 0.
  - The shadow file is cleared by `reset` and by `clear`.
- Undefined: no shadow file, and the ports do not exist.

## Structure
- Package `riscv_wb_pkg`: `chk_state_e` (IDLE/RUN/DONE) and a `wb_entry_t` struct {a, d}.
- Sub-module `wb_exp_fifo`: parametrised synchronous FIFO with push/pop/flush/occupancy, instantiated once for the expected queue.

## Test plan
- Load (1,DEADBEEF),(2,12345678),(3,FEDCBA98); drive matching `wb_e` writes on consecutive cycles → `done`, `pass`=1, `match_count`=3, `err_count`=0.
- Same load, second write `wb_d`=12345679 → `mismatch` pulse one cycle later, `err_count`=1, `first_err_idx`=1, `pass`=0.
- Same load, third write `wb_a`=4 with correct data → `err_count`=1, `first_err_idx`=2.
- TIMEOUT=8, load 2 entries, drive one write then idle → `done`, `timeout`=1 eight cycles after the write, `match_count`=1.
- Fill DEPTH entries → `exp_ready`=0; extra push is dropped; `reset` mid-RUN → all outputs 0, `exp_ready`=1.
- With `RVP_WB_SHADOW_EN` defined: writes (1,DEADBEEF) and (0,FFFFFFFF) → `sh_a`=1 gives DEADBEEF, `sh_a`=0 gives 0; after `clear`, `sh_a`=1 gives 0.

Source files
------------

// File: rtl/riscv_wb_pkg.sv
// Shared types for the riscv_pipeline writeback-stream checker.
// wb_entry_t matches the default XLEN=32 / RA_W=5 configuration.
package riscv_wb_pkg;

    localparam int WB_XLEN = 32;
    localparam int WB_RA_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    typedef struct packed {
        logic [WB_RA_W-1:0] a;
        logic [WB_XLEN-1:0] d;
    } wb_entry_t;

endpackage

// File: rtl/wb_exp_fifo.sv
// Synchronous FIFO holding expected writeback entries; wrapping pointers,
// with an explicit occupancy count to tell full from empty.
module wb_exp_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_wb_checker.sv
// In-order writeback-stream checker: compares each wb_e write against a
// preloaded expected queue. Optional shadow register file: RVP_WB_SHADOW_EN.
module riscv_wb_checker
    import riscv_wb_pkg::*;
#(
    parameter int XLEN    = WB_XLEN,
    parameter int RA_W    = WB_RA_W,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         exp_valid,
    output logic                         exp_ready,
    input  logic [RA_W-1:0]              exp_a,
    input  logic [XLEN-1:0]              exp_d,
    input  logic                         start,
    input  logic                         clear,
    input  logic [RA_W-1:0]              wb_a,
    input  logic [XLEN-1:0]              wb_d,
    input  logic                         wb_e,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         timeout,
    output logic                         mismatch,
    output logic [$clog2(DEPTH+1)-1:0]   match_count,
    output logic [$clog2(DEPTH+1)-1:0]   err_count,
    output logic [$clog2(DEPTH)-1:0]     first_err_idx,
    output chk_state_e                   dbg_state
`ifdef RVP_WB_SHADOW_EN
    ,
    input  logic [RA_W-1:0]              sh_a,
    output logic [XLEN-1:0]              sh_d
`endif
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT+1);
    localparam int EW = RA_W + XLEN;

    // Handshake: an expected entry transfers on a cycle where exp_valid and
    // exp_ready are both high; exp_ready is only ever high in IDLE when not full.
    chk_state_e     state;
    logic [TW-1:0]  idle_cnt;
    logic [EW-1:0]  head;
    logic [CW-1:0]  occ;
    logic           full;
    logic           push;
    logic           pop;
    logic           flush;
    logic           hit;
    logic [CW-1:0]  pop_idx;

    assign exp_ready = (state == IDLE) && !full;
    assign push      = exp_valid && exp_ready;
    assign pop       = (state == RUN) && wb_e;
    assign flush     = (state == DONE) && clear;
    assign hit       = (wb_a == head[EW-1:XLEN]) && (wb_d == head[XLEN-1:0]);
    assign pop_idx   = match_count + err_count;

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign pass      = done && (err_count == '0) && !timeout;
    assign dbg_state = state;

    wb_exp_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_exp_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   ({exp_a, exp_d}),
        .head  (head),
        .count (occ),
        .full  (full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            match_count   <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            timeout       <= 1'b0;
            mismatch      <= 1'b0;
            idle_cnt      <= '0;
        end else begin
            mismatch <= 1'b0;
            case (state)
                IDLE: begin
                    // An entry pushed in the start cycle counts toward the run.
                    if (start && (occ != '0 || push)) begin
                        state    <= RUN;
                        idle_cnt <= '0;
                    end
                end
                RUN: begin
                    if (wb_e) begin
                        idle_cnt <= '0;
                        if (hit) begin
                            match_count <= match_count + 1'b1;
                        end else begin
                            err_count <= err_count + 1'b1;
                            mismatch  <= 1'b1;
                            if (err_count == '0) begin
                                first_err_idx <= pop_idx[IW-1:0];
                            end
                        end
                        if (occ == CW'(1)) begin
                            state <= DONE;
                        end
                    end else if (idle_cnt == TW'(TIMEOUT-1)) begin
                        state   <= DONE;
                        timeout <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (clear) begin
                        state         <= IDLE;
                        match_count   <= '0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                        timeout       <= 1'b0;
                        idle_cnt      <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RVP_WB_SHADOW_EN
    logic [XLEN-1:0] sh_rf [2**RA_W];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < 2**RA_W; i++) begin
                sh_rf[i] <= '0;
            end
        end else if (pop && wb_a != '0) begin
            sh_rf[wb_a] <= wb_d;
        end
    end

    assign sh_d = (sh_a == '0) ? '0 : sh_rf[sh_a];
`endif

endmodule
